// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 8-bit XNOR weight LFSR stream: self-synchronises,
// then flags and counts mispredicted words while locked.
module lfsr_seq_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       expected,
  output logic             lockup
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(LOSS_CNT + 1);
  localparam logic [GW:0]      LOCK_V = (GW + 1)'(LOCK_CNT);
  localparam logic [BW:0]      LOSS_V = (BW + 1)'(LOSS_CNT);
  localparam logic [GW:0]      G_ONE  = (GW + 1)'(1);
  localparam logic [BW:0]      B_ONE  = (BW + 1)'(1);
  localparam logic [ERR_W-1:0] E_ONE  = ERR_W'(1);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic [7:0]       expected_q, expected_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             lockup_q, lockup_d;
  logic [GW:0]      good_inc;
  logic [BW:0]      bad_inc;

  // XNOR feedback: 8'hFF maps to itself, so it can never seed the predictor
  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {~(x[4] ^ x[3] ^ x[2] ^ x[0]), x[7:1]};
  endfunction

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    bad_d       = bad_q;
    expected_d  = expected_q;
    err_cnt_d   = err_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    lockup_d    = 1'b0;
    good_inc    = {1'b0, good_q} + G_ONE;
    bad_inc     = {1'b0, bad_q} + B_ONE;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (din == 8'hFF) begin
            lockup_d = 1'b1;
          end else begin
            expected_d = nxt(din);
            good_d     = '0;
            state_d    = VERIFY;
          end
        end
        VERIFY: begin
          if (din == 8'hFF) begin
            lockup_d = 1'b1;
            state_d  = HUNT;
          end else if (din == expected_q) begin
            expected_d = nxt(din);
            good_d     = good_inc[GW-1:0];
            if (good_inc == LOCK_V) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            expected_d = nxt(din);
            good_d     = '0;
          end
        end
        LOCKED: begin
          // Flywheel: keep predicting from our own sequence, never reseed from din
          expected_d = nxt(expected_q);
          if (din == expected_q) begin
            bad_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + E_ONE;
            if (bad_inc == LOSS_V) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              bad_d    = '0;
            end else begin
              bad_d = bad_inc[BW-1:0];
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q     <= HUNT;
      good_q      <= '0;
      bad_q       <= '0;
      expected_q  <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      expected_q  <= expected_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      lockup_q    <= lockup_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign expected  = expected_q;
  assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios plus a randomized stream,
// all compared against a behavioural model of the checker.
module tb_lfsr_seq_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 3;
  localparam int EMAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n, din_valid, clr;
  logic [7:0]  din;
  logic        locked, err_pulse, lockup;
  logic [15:0] err_cnt;
  logic [7:0]  expected;

  logic        b_rst_n, b_din_valid, b_clr;
  logic [7:0]  b_din;
  logic        b_locked, b_err_pulse, b_lockup;
  logic [1:0]  b_err_cnt;
  logic [7:0]  b_expected;

  int checks = 0;
  int errors = 0;

  int         m_mode, m_good, m_bad, m_err;
  logic [7:0] m_exp;
  bit         m_locked, m_ep, m_lu;

  always #5 clk = ~clk;

  lfsr_seq_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .expected(expected), .lockup(lockup)
  );

  lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(8), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(b_rst_n), .din(b_din), .din_valid(b_din_valid), .clr(b_clr),
    .locked(b_locked), .err_pulse(b_err_pulse), .err_cnt(b_err_cnt),
    .expected(b_expected), .lockup(b_lockup)
  );

  function automatic logic [7:0] nxt(input logic [7:0] x);
    logic q;
    q = ~(^(x & 8'h1D));
    return {q, x[7:1]};
  endfunction

  function automatic logic [26:0] obs();
    return {locked, err_pulse, err_cnt, expected, lockup};
  endfunction

  function automatic logic [26:0] mdl();
    return {m_locked, m_ep, 16'(m_err), m_exp, m_lu};
  endfunction

  task automatic model_update(input bit r, input bit c, input bit v, input logic [7:0] d);
    if (!r || c) begin
      m_mode = 0; m_good = 0; m_bad = 0; m_err = 0;
      m_exp = 8'h00; m_locked = 0; m_ep = 0; m_lu = 0;
    end else begin
      m_ep = 0;
      m_lu = 0;
      if (v) begin
        case (m_mode)
          0: if (d == 8'hFF) m_lu = 1;
             else begin m_exp = nxt(d); m_good = 0; m_mode = 1; end
          1: if (d == 8'hFF) begin m_lu = 1; m_mode = 0; end
             else if (d == m_exp) begin
               m_exp = nxt(d);
               m_good++;
               if (m_good == LOCK) begin m_mode = 2; m_locked = 1; end
             end else begin m_exp = nxt(d); m_good = 0; end
          default: begin
            if (d != m_exp) begin
              m_ep = 1;
              if (m_err < EMAX) m_err++;
              m_bad++;
              if (m_bad == LOSS) begin m_mode = 0; m_locked = 0; m_bad = 0; end
            end else m_bad = 0;
            m_exp = nxt(m_exp);
          end
        endcase
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit v, input logic [7:0] d);
    rst_n = r; clr = c; din_valid = v; din = d;
    @(posedge clk);
    model_update(r, c, v, d);
    #1;
  endtask

  task automatic stepb(input bit r, input bit c, input bit v, input logic [7:0] d);
    b_rst_n = r; b_clr = c; b_din_valid = v; b_din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic lock_from(input logic [7:0] seed);
    logic [7:0] w;
    w = seed;
    for (int i = 0; i <= LOCK; i++) begin
      step(1, 0, 1, w);
      w = nxt(w);
    end
  endtask

  task automatic test_reset();
    step(0, 0, 1, 8'h5A);
    step(0, 0, 0, 8'h00);
    checks++;
    if (obs() !== 27'd0) begin
      errors++;
      $display("FAIL reset_zero: got %h want 0", obs());
    end
    checks++;
    if (obs() !== mdl()) begin
      errors++;
      $display("FAIL reset_model: got %h want %h", obs(), mdl());
    end
  endtask

  task automatic test_lock();
    logic [7:0] seq [5];
    seq = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0};
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, seq[i]);
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL lock_seq[%0d]: got %h want %h", i, obs(), mdl());
      end
    end
    checks++;
    if ({locked, expected, err_cnt} !== {1'b1, 8'h78, 16'd0}) begin
      errors++;
      $display("FAIL lock_final: got locked=%0b exp=%h cnt=%0d want 1 78 0", locked, expected, err_cnt);
    end
  endtask

  task automatic test_single_error();
    logic [7:0] words [3];
    logic [26:0] want [3];
    words = '{8'h78, 8'h00, nxt(8'hBC)};
    want  = '{{1'b1, 1'b0, 16'd0, 8'hBC, 1'b0},
              {1'b1, 1'b1, 16'd1, nxt(8'hBC), 1'b0},
              {1'b1, 1'b0, 16'd1, nxt(nxt(8'hBC)), 1'b0}};
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, words[i]);
      checks++;
      if (obs() !== want[i]) begin
        errors++;
        $display("FAIL single_err[%0d]: got %h want %h", i, obs(), want[i]);
      end
    end
    // two more wrong words must not drop lock if bad was cleared by the good word
    for (int i = 0; i < 2; i++) step(1, 0, 1, m_exp ^ 8'h01);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 16'd3) begin
      errors++;
      $display("FAIL bad_cleared: got locked=%0b cnt=%0d want 1 3", locked, err_cnt);
    end
  endtask

  task automatic test_loss();
    logic [7:0] w;
    step(1, 1, 0, 8'h00);
    lock_from(8'($urandom_range(0, 254)));
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, m_exp ^ 8'h10);
      checks++;
      if (obs() !== mdl() || err_pulse !== 1'b1 || err_cnt !== 16'(i + 1)) begin
        errors++;
        $display("FAIL loss[%0d]: got %h want %h", i, obs(), mdl());
      end
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL loss_unlock: got locked=%0b want 0", locked);
    end
    w = 8'($urandom_range(0, 254));
    step(1, 0, 1, w);
    checks++;
    if (expected !== nxt(w) || locked !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL loss_reseed: got exp=%h locked=%0b ep=%0b want %h 0 0", expected, locked, err_pulse, nxt(w));
    end
  endtask

  task automatic test_lockup();
    logic [7:0] words [7];
    logic       want_lu [7];
    words   = '{8'hFF, 8'h00, 8'hFF, 8'h80, 8'hC0, 8'hE0, 8'hF0};
    want_lu = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    step(1, 1, 0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 1, words[i]);
      checks++;
      if (obs() !== mdl() || lockup !== want_lu[i] || locked !== 1'b0) begin
        errors++;
        $display("FAIL lockup[%0d]: got %h (lu=%0b) want %h (lu=%0b)", i, obs(), lockup, mdl(), want_lu[i]);
      end
    end
  endtask

  task automatic test_clr_priority();
    step(1, 1, 0, 8'h00);
    lock_from(8'h3C);
    step(1, 0, 1, m_exp ^ 8'h01);
    step(1, 0, 1, m_exp ^ 8'h01);
    checks++;
    if (err_cnt !== 16'd2 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre: got cnt=%0d locked=%0b want 2 1", err_cnt, locked);
    end
    step(1, 1, 1, m_exp ^ 8'h01);
    checks++;
    if (obs() !== 27'd0) begin
      errors++;
      $display("FAIL clr_wins: got %h want 0", obs());
    end
  endtask

  task automatic test_gaps();
    step(1, 1, 0, 8'h00);
    lock_from(8'h11);
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) step(1, 0, 0, 8'($urandom));
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL gap_hold[%0d]: got %h want %h", g, obs(), mdl());
      end
      step(1, 0, 1, m_exp);
      checks++;
      if (locked !== 1'b1 || err_pulse !== 1'b0 || obs() !== mdl()) begin
        errors++;
        $display("FAIL gap_resume[%0d]: got %h want %h", g, obs(), mdl());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] tx;
    int r;
    tx = 8'h00;
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       step(1, 0, 0, 8'($urandom));
      else if (r < 13) step(1, 0, 1, 8'($urandom));
      else if (r < 15) step(1, 0, 1, 8'hFF);
      else if (r < 16) step(1, 1, 1, tx);
      else if (r < 17) step(0, 0, 1, tx);
      else begin
        step(1, 0, 1, tx);
        tx = nxt(tx);
        if (tx == 8'hFF) tx = 8'h00;
      end
      if (r >= 8 && r < 13) tx = nxt(tx);
      checks++;
      if (obs() !== mdl()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", n, obs(), mdl());
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] seq [5];
    logic [7:0] e;
    logic [1:0] want_cnt;
    seq = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0};
    stepb(0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) stepb(1, 0, 1, seq[i]);
    checks++;
    if (b_locked !== 1'b1 || b_expected !== 8'h78) begin
      errors++;
      $display("FAIL sat_lock: got locked=%0b exp=%h want 1 78", b_locked, b_expected);
    end
    e = 8'h78;
    for (int i = 0; i < 5; i++) begin
      stepb(1, 0, 1, e ^ 8'h01);
      e = nxt(e);
      want_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
      checks++;
      if ({b_err_pulse, b_err_cnt, b_locked, b_expected} !== {1'b1, want_cnt, 1'b1, e}) begin
        errors++;
        $display("FAIL sat_err[%0d]: got ep=%0b cnt=%0d locked=%0b exp=%h want 1 %0d 1 %h",
                 i, b_err_pulse, b_err_cnt, b_locked, b_expected, want_cnt, e);
      end
    end
    stepb(0, 0, 1, e ^ 8'h01);
    checks++;
    if ({b_locked, b_err_pulse, b_err_cnt, b_expected, b_lockup} !== 13'd0) begin
      errors++;
      $display("FAIL sat_reset: got locked=%0b ep=%0b cnt=%0d exp=%h lu=%0b want all 0",
               b_locked, b_err_pulse, b_err_cnt, b_expected, b_lockup);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; din_valid = 1'b0; din = 8'h00;
    b_rst_n = 1'b0; b_clr = 1'b0; b_din_valid = 1'b0; b_din = 8'h00;
    model_update(0, 0, 0, 8'h00);
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_lockup();
    test_clr_priority();
    test_gaps();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
